// File: rtl/queue_pkt_drain.sv
`default_nettype none
// ============================================================================
// Module   : queue_pkt_drain
// Purpose  : Drains a 32-bit first-word-fall-through queue, splits the word
//            stream into header-delimited packets and presents them on a
//            registered valid/ready stream with first/last markers. A stall
//            watchdog force-closes packets whose payload stops arriving.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            q_dout, q_empty   - queue head word / queue empty
//            q_rd_en           - combinational pop strobe
//            out_valid/ready   - output handshake
//            out_data/first/last - output word and packet delimiters
//            err_timeout       - sticky, a packet was force-closed
//            pkt_count         - packets delivered (last word handshaked)
// Revision : 1.0 - initial release
// ============================================================================
module queue_pkt_drain #(
  parameter int          LEN_LSB  = 20,
  parameter int          LEN_W    = 6,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] PAD_WORD = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] q_dout,
  input  logic        q_empty,
  output logic        q_rd_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_first,
  output logic        out_last,
  output logic        err_timeout,
  output logic [15:0] pkt_count
);

  localparam logic [7:0]       C_TIMEOUT = TIMEOUT[7:0];
  localparam logic [LEN_W-1:0] C_REM_ONE = LEN_W'(1);

  typedef enum logic [0:0] {
    HDR  = 1'b0,
    BODY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [7:0]        stall_q, stall_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;
  logic              err_q, err_d;
  logic [15:0]       pkt_q, pkt_d;

  logic              w_slot_free;
  logic              w_ld;
  logic              w_pad;
  logic [LEN_W-1:0]  w_len;

  // The output register can take a new word when it is empty or its current
  // word is being accepted this very cycle.
  assign w_slot_free = !out_valid_q || out_ready;
  assign w_ld        = w_slot_free && !q_empty && !rst;
  // A real word always wins over the pad: if payload shows up exactly on the
  // timeout cycle it is loaded and the watchdog restarts.
  assign w_pad       = (state_q == BODY) && (stall_q == C_TIMEOUT) &&
                       w_slot_free && q_empty && !rst;
  assign w_len       = q_dout[LEN_LSB +: LEN_W];

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    stall_d     = stall_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    pkt_d       = pkt_q;

    if (out_valid_q && out_ready && out_last_q) begin
      pkt_d = pkt_q + 16'd1;
    end

    if (w_ld) begin
      out_valid_d = 1'b1;
      out_data_d  = q_dout;
      stall_d     = 8'd0;
      if (state_q == HDR) begin
        out_first_d = 1'b1;
        if (w_len == '0) begin
          // Header-only packet: closes immediately, next word is a header.
          out_last_d = 1'b1;
        end else begin
          out_last_d = 1'b0;
          rem_d      = w_len;
          state_d    = BODY;
        end
      end else begin
        out_first_d = 1'b0;
        out_last_d  = (rem_q == C_REM_ONE);
        rem_d       = rem_q - C_REM_ONE;
        if (rem_q == C_REM_ONE) begin
          state_d = HDR;
        end
      end
    end else if (w_pad) begin
      out_valid_d = 1'b1;
      out_data_d  = PAD_WORD;
      out_first_d = 1'b0;
      out_last_d  = 1'b1;
      err_d       = 1'b1;
      rem_d       = '0;
      stall_d     = 8'd0;
      state_d     = HDR;
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
      // Only a starved queue counts; downstream backpressure leaves the
      // slot occupied and therefore does not advance the watchdog.
      if ((state_q == BODY) && w_slot_free && q_empty) begin
        stall_d = stall_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDR;
      rem_q       <= '0;
      stall_q     <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      pkt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_q     <= stall_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      pkt_q       <= pkt_d;
    end
  end

  assign q_rd_en     = w_ld;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_first   = out_first_q;
  assign out_last    = out_last_q;
  assign err_timeout = err_q;
  assign pkt_count   = pkt_q;

endmodule
`default_nettype wire

// File: tb/tb_queue_pkt_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_pkt_drain
// Purpose  : Self-checking bench for queue_pkt_drain. The bench plays the
//            FWFT queue, parses pushed words into expected output beats and
//            compares them in order against handshaked output words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_pkt_drain;

  localparam int          C_TIMEOUT = 255;
  localparam logic [31:0] C_PAD     = 32'h0;

  logic        clk;
  logic        rst;
  logic [31:0] q_dout;
  logic        q_empty;
  logic        q_rd_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_first;
  logic        out_last;
  logic        err_timeout;
  logic [15:0] pkt_count;

  queue_pkt_drain #(
    .LEN_LSB (20),
    .LEN_W   (6),
    .TIMEOUT (C_TIMEOUT),
    .PAD_WORD(C_PAD)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .q_dout     (q_dout),
    .q_empty    (q_empty),
    .q_rd_en    (q_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_first  (out_first),
    .out_last   (out_last),
    .err_timeout(err_timeout),
    .pkt_count  (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_pops   = 0;
  logic [31:0] qm[$];     // queue contents
  logic [33:0] sb[$];     // expected {data, first, last}
  int          acc_cyc[$];
  bit          p_body   = 1'b0;
  int          p_rem    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic refresh();
    q_empty = (qm.size() == 0);
    q_dout  = q_empty ? 32'h0 : qm[0];
  endtask

  // Independent packet parser producing the expected output beat.
  task automatic push_word(input logic [31:0] w);
    logic [5:0] len;
    logic       f;
    logic       l;
    len = w[25:20];
    if (!p_body) begin
      f = 1'b1;
      l = (len == 6'd0);
      if (len != 6'd0) begin
        p_body = 1'b1;
        p_rem  = int'(len);
      end
    end else begin
      f     = 1'b0;
      p_rem = p_rem - 1;
      l     = (p_rem == 0);
      if (p_rem == 0) p_body = 1'b0;
    end
    sb.push_back({w, f, l});
    qm.push_back(w);
    refresh();
  endtask

  task automatic push_pad();
    sb.push_back({C_PAD, 1'b0, 1'b1});
    p_body = 1'b0;
    p_rem  = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((sb.size() != 0 || qm.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    if (sb.size() != 0 || qm.size() != 0) check("drain_bound", 32'(sb.size()), 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Queue side: pop after the edge so the DUT sampled the pre-edge head word.
  always @(posedge clk) begin : p_pop
    logic rd;
    rd = q_rd_en;
    #1;
    if (rd && qm.size() > 0) begin
      void'(qm.pop_front());
      n_pops++;
    end
    refresh();
  end

  // Output side: compare every handshaked word against the scoreboard.
  always @(negedge clk) begin : p_mon
    logic [33:0] e;
    if (!rst && out_valid && out_ready) begin
      acc_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_word", out_data, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("data",  out_data,  e[33:2]);
        check("first", out_first, e[1]);
        check("last",  out_last,  e[0]);
      end
    end
  end

  initial begin : g_guard
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not terminate");
  end

  initial begin : p_main
    bit pat[7];
    logic [31:0] held;
    bit have;
    int n0;

    rst       = 1'b1;
    out_ready = 1'b0;
    refresh();
    step();
    step();
    // Reset state
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data, 0);
    check("rst_first", out_first, 0);
    check("rst_last",  out_last, 0);
    check("rst_err",   err_timeout, 0);
    check("rst_pkt",   pkt_count, 0);
    check("rst_rden",  q_rd_en, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // Basic len-3 packet, latency and throughput
    n_pops = 0;
    n0 = acc_cyc.size();
    push_word(32'h0030_0005);
    push_word(32'h0000_000A);
    push_word(32'h0000_000B);
    push_word(32'h0000_000C);
    step();
    check("latency_valid", out_valid, 1);
    wait_drain(50);
    step();
    check("t1_pkt",  pkt_count, 1);
    check("t1_pops", n_pops, 4);
    if (acc_cyc.size() >= n0 + 4) check("t1_burst", acc_cyc[n0+3] - acc_cyc[n0], 3);
    else check("t1_accepts", acc_cyc.size() - n0, 4);

    // Zero-length header followed by len-1 packet, no bubble
    n0 = acc_cyc.size();
    push_word(32'h0000_0011);
    push_word(32'h0010_0022);
    push_word(32'h0000_0033);
    wait_drain(50);
    step();
    check("t2_pkt", pkt_count, 3);
    if (acc_cyc.size() >= n0 + 3) check("t2_nobubble", acc_cyc[n0+1] - acc_cyc[n0], 1);
    else check("t2_accepts", acc_cyc.size() - n0, 3);

    // Backpressure during a len-2 packet
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    push_word(32'h0020_0044);
    push_word(32'h0000_0055);
    push_word(32'h0000_0066);
    have = 1'b0;
    held = 32'h0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      #1;
      if (!out_ready && out_valid) begin
        check("stall_rden", q_rd_en, 0);
        if (have) check("stall_hold", out_data, held);
        held = out_data;
        have = 1'b1;
      end else begin
        have = 1'b0;
      end
      step();
    end
    out_ready = 1'b1;
    wait_drain(50);
    step();
    check("t3_pkt", pkt_count, 4);

    // Long downstream stall must not trip the watchdog
    out_ready = 1'b0;
    push_word(32'h0020_00C1);
    push_word(32'h0000_00C2);
    push_word(32'h0000_00C3);
    repeat (400) step();
    check("t5_err_stalled", err_timeout, 0);
    out_ready = 1'b1;
    wait_drain(50);
    step();
    check("t5_err", err_timeout, 0);
    check("t5_pkt", pkt_count, 5);

    // Starved payload: pad close after TIMEOUT starved cycles plus the load
    n0 = acc_cyc.size();
    push_word(32'h0020_0077);
    push_word(32'h0000_0088);
    push_pad();
    wait_drain(C_TIMEOUT + 100);
    step();
    check("t4_err", err_timeout, 1);
    check("t4_pkt", pkt_count, 6);
    if (acc_cyc.size() >= n0 + 3) check("t4_pad_delay", acc_cyc[n0+2] - acc_cyc[n0+1], C_TIMEOUT + 1);
    else check("t4_accepts", acc_cyc.size() - n0, 3);
    push_word(32'h0000_00BB);   // late word parsed as a header-only packet
    wait_drain(50);
    step();
    check("t4_late_pkt", pkt_count, 7);
    check("t4_err_sticky", err_timeout, 1);

    // Reset in the middle of a packet body
    push_word(32'h0030_00D1);
    push_word(32'h0000_00D2);
    step();
    step();
    step();
    rst = 1'b1;
    qm.delete();
    sb.delete();
    p_body = 1'b0;
    p_rem  = 0;
    push_word(32'h0010_00E1);
    push_word(32'h0000_00E2);
    step();
    check("t6_valid", out_valid, 0);
    check("t6_data",  out_data, 0);
    check("t6_first", out_first, 0);
    check("t6_last",  out_last, 0);
    check("t6_err",   err_timeout, 0);
    check("t6_pkt",   pkt_count, 0);
    check("t6_rden",  q_rd_en, 0);
    rst = 1'b0;
    wait_drain(50);
    step();
    check("t6_fresh_pkt", pkt_count, 1);
    check("t6_fresh_err", err_timeout, 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
